// File: rtl/axi_dma_cmd_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : axi_dma_cmd_arbiter_if
//  Function : Requester and DMA command bundle around the command arbiter.
//  Revision : 1.0  initial release
// ============================================================================
interface axi_dma_cmd_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_WD = 32,
    parameter int LEN_WD  = 32,
    parameter int ID_WD   = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ*ADDR_WD-1:0] req_src_addr;
    logic [NUM_REQ*ADDR_WD-1:0] req_dst_addr;
    logic [NUM_REQ*2-1:0]       req_burst;
    logic [NUM_REQ*LEN_WD-1:0]  req_len;
    logic [NUM_REQ*3-1:0]       req_size;
    logic [NUM_REQ-1:0]         req_ready;

    logic                       cmd_valid;
    logic [ADDR_WD-1:0]         cmd_src_addr;
    logic [ADDR_WD-1:0]         cmd_dst_addr;
    logic [1:0]                 cmd_burst;
    logic [LEN_WD-1:0]          cmd_len;
    logic [2:0]                 cmd_size;
    logic [ID_WD-1:0]           cmd_id;
    logic                       cmd_ready;

    modport master (
        output req_valid, req_src_addr, req_dst_addr, req_burst, req_len, req_size,
        output cmd_ready,
        input  req_ready,
        input  cmd_valid, cmd_src_addr, cmd_dst_addr, cmd_burst, cmd_len, cmd_size, cmd_id
    );

    modport slave (
        input  req_valid, req_src_addr, req_dst_addr, req_burst, req_len, req_size,
        input  cmd_ready,
        output req_ready,
        output cmd_valid, cmd_src_addr, cmd_dst_addr, cmd_burst, cmd_len, cmd_size, cmd_id
    );
endinterface
`default_nettype wire

// File: rtl/axi_dma_cmd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : axi_dma_cmd_arbiter
//  Function : Round-robin share of one registered DMA command slot; drops
//             zero-length commands locally and tags commands with the winner.
//  Revision : 1.0  initial release
// ============================================================================
module axi_dma_cmd_arbiter #(
    parameter  int NUM_REQ = 4,
    parameter  int ADDR_WD = 32,
    parameter  int LEN_WD  = 32,
    localparam int ID_WD   = $clog2(NUM_REQ)
) (
    input  wire logic              clk,
    input  wire logic              rst,
    axi_dma_cmd_arbiter_if.slave   bus,
    output logic                   drop_pulse,
    output logic                   busy
);
    localparam logic [0:0] c_EMPTY = 1'b0;
    localparam logic [0:0] c_FULL  = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_next_state;
    logic [ID_WD-1:0]   r_last_ptr;
    logic [ID_WD-1:0]   r_id;
    logic [ADDR_WD-1:0] r_src;
    logic [ADDR_WD-1:0] r_dst;
    logic [LEN_WD-1:0]  r_len;
    logic [1:0]         r_burst;
    logic [2:0]         r_size;
    logic               r_drop;

    logic               w_load_en;
    logic               w_found;
    logic [ID_WD-1:0]   w_gnt_id;
    logic               w_grant;
    logic               w_zero_len;
    logic               w_load;
    logic               w_cmd_valid;
    logic               w_busy;

    logic [ADDR_WD-1:0] w_src   [NUM_REQ];
    logic [ADDR_WD-1:0] w_dst   [NUM_REQ];
    logic [LEN_WD-1:0]  w_len   [NUM_REQ];
    logic [1:0]         w_burst [NUM_REQ];
    logic [2:0]         w_size  [NUM_REQ];

    generate
        for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
            assign w_src[i]   = bus.req_src_addr[i*ADDR_WD +: ADDR_WD];
            assign w_dst[i]   = bus.req_dst_addr[i*ADDR_WD +: ADDR_WD];
            assign w_len[i]   = bus.req_len[i*LEN_WD +: LEN_WD];
            assign w_burst[i] = bus.req_burst[i*2 +: 2];
            assign w_size[i]  = bus.req_size[i*3 +: 3];
        end
    endgenerate

    assign w_load_en = (r_state == c_EMPTY) || bus.cmd_ready;

    // Search starts one past the last winner; modulo keeps non-power-of-two counts in range.
    always_comb begin : p_arbiter
        logic [ID_WD-1:0] v_idx;
        v_idx    = '0;
        w_found  = 1'b0;
        w_gnt_id = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            v_idx = ID_WD'((int'(r_last_ptr) + k) % NUM_REQ);
            if (!w_found && bus.req_valid[v_idx]) begin
                w_found  = 1'b1;
                w_gnt_id = v_idx;
            end
        end
    end

    assign w_grant       = w_found && w_load_en && !rst;
    assign w_zero_len    = (w_len[w_gnt_id] == '0);
    assign w_load        = w_grant && !w_zero_len;
    assign bus.req_ready = w_grant ? (NUM_REQ'(1) << w_gnt_id) : '0;

    always_ff @(posedge clk) begin : p_state_reg
        if (rst) begin
            r_state <= c_EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin : p_next_state
        w_next_state = r_state;
        case (r_state)
            c_EMPTY: if (w_load) w_next_state = c_FULL;
            c_FULL:  if (bus.cmd_ready && !w_load) w_next_state = c_EMPTY;
            default: w_next_state = c_EMPTY;
        endcase
    end

    always_comb begin : p_outputs
        w_cmd_valid = (r_state == c_FULL);
        w_busy      = (|bus.req_valid) || (r_state == c_FULL);
    end

    always_ff @(posedge clk) begin : p_datapath
        if (rst) begin
            r_last_ptr <= ID_WD'(NUM_REQ - 1);
            r_id       <= '0;
            r_src      <= '0;
            r_dst      <= '0;
            r_len      <= '0;
            r_burst    <= 2'b01;
            r_size     <= '0;
            r_drop     <= 1'b0;
        end else begin
            r_drop <= w_grant && w_zero_len;
            if (w_grant) begin
                r_last_ptr <= w_gnt_id;
            end
            if (w_load) begin
                r_id    <= w_gnt_id;
                r_src   <= w_src[w_gnt_id];
                r_dst   <= w_dst[w_gnt_id];
                r_len   <= w_len[w_gnt_id];
                r_burst <= w_burst[w_gnt_id];
                r_size  <= w_size[w_gnt_id];
            end
        end
    end

    assign bus.cmd_valid    = w_cmd_valid;
    assign bus.cmd_src_addr = r_src;
    assign bus.cmd_dst_addr = r_dst;
    assign bus.cmd_burst    = r_burst;
    assign bus.cmd_len      = r_len;
    assign bus.cmd_size     = r_size;
    assign bus.cmd_id       = r_id;
    assign drop_pulse       = r_drop;
    assign busy             = w_busy;
endmodule
`default_nettype wire

// File: tb/tb_axi_dma_cmd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi_dma_cmd_arbiter
//  Function : Directed and random stimulus for the DMA command arbiter.
//  Revision : 1.0  initial release
// ============================================================================
module tb_axi_dma_cmd_arbiter;
    localparam int N4 = 4;
    localparam int N3 = 3;
    localparam int AW = 32;
    localparam int LW = 32;

    logic clk = 1'b0;
    logic rst;
    logic drop4, busy4, drop3, busy3;

    always #5 clk = ~clk;

    axi_dma_cmd_arbiter_if #(.NUM_REQ(N4), .ADDR_WD(AW), .LEN_WD(LW)) bus4 ();
    axi_dma_cmd_arbiter_if #(.NUM_REQ(N3), .ADDR_WD(AW), .LEN_WD(LW)) bus3 ();

    axi_dma_cmd_arbiter #(.NUM_REQ(N4), .ADDR_WD(AW), .LEN_WD(LW)) dut4 (
        .clk(clk), .rst(rst), .bus(bus4), .drop_pulse(drop4), .busy(busy4));
    axi_dma_cmd_arbiter #(.NUM_REQ(N3), .ADDR_WD(AW), .LEN_WD(LW)) dut3 (
        .clk(clk), .rst(rst), .bus(bus3), .drop_pulse(drop3), .busy(busy3));

    // Requester-side view of the four-port instance
    bit          v4 [N4];
    logic [31:0] s4 [N4];
    logic [31:0] d4 [N4];
    logic [31:0] l4 [N4];
    logic [1:0]  b4 [N4];
    logic [2:0]  z4 [N4];

    // Reference: contents of the single output slot plus the last winner
    bit          m_full;
    logic [31:0] m_src, m_dst, m_len;
    logic [1:0]  m_burst;
    logic [2:0]  m_size;
    int          m_id, m_last;
    bit          m_drop;

    int n_vec = 0;
    int n_err = 0;
    int w;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_full = 0; m_src = 0; m_dst = 0; m_len = 0;
        m_burst = 2'b01; m_size = 0; m_id = 0; m_drop = 0; m_last = N4 - 1;
    endtask

    task automatic present(input int i, input logic [31:0] src, input logic [31:0] dst,
                           input logic [31:0] len, input logic [1:0] burst, input logic [2:0] size);
        v4[i] = 1; s4[i] = src; d4[i] = dst; l4[i] = len; b4[i] = burst; z4[i] = size;
    endtask

    task automatic clear_all();
        for (int i = 0; i < N4; i++) v4[i] = 0;
    endtask

    task automatic drive4();
        for (int i = 0; i < N4; i++) begin
            bus4.req_valid[i]             = v4[i];
            bus4.req_src_addr[i*AW +: AW] = s4[i];
            bus4.req_dst_addr[i*AW +: AW] = d4[i];
            bus4.req_len[i*LW +: LW]      = l4[i];
            bus4.req_burst[i*2 +: 2]      = b4[i];
            bus4.req_size[i*3 +: 3]       = z4[i];
        end
    endtask

    // One clock of the four-port instance, entered and left just after a falling edge.
    task automatic cyc4(input bit rdy, input bit do_rst, output int win);
        logic [3:0] exp_rdy;
        bit         any;
        drive4();
        bus4.cmd_ready = rdy;
        rst            = do_rst;
        #1;
        win = -1;
        any = 0;
        for (int k = 1; k <= N4; k++) begin
            int i;
            i = (m_last + k) % N4;
            if (win < 0 && v4[i]) win = i;
            any = any | v4[k-1];
        end
        if (do_rst || (m_full && !rdy)) win = -1;
        exp_rdy = (win >= 0) ? 4'(1 << win) : 4'b0;
        chk("req_ready", bus4.req_ready, exp_rdy);
        chk("busy", busy4, any || m_full);
        @(posedge clk);
        if (do_rst) begin
            model_reset();
        end else begin
            m_drop = (win >= 0) && (l4[win] == 0);
            if (win >= 0) m_last = win;
            if (win >= 0 && l4[win] != 0) begin
                m_src = s4[win]; m_dst = d4[win]; m_len = l4[win];
                m_burst = b4[win]; m_size = z4[win]; m_id = win; m_full = 1;
            end else if (m_full && rdy) begin
                m_full = 0;
            end
        end
        if (win >= 0) v4[win] = 0;
        @(negedge clk);
        chk("cmd_valid", bus4.cmd_valid, m_full);
        chk("cmd_src", bus4.cmd_src_addr, m_src);
        chk("cmd_dst", bus4.cmd_dst_addr, m_dst);
        chk("cmd_len", bus4.cmd_len, m_len);
        chk("cmd_burst", bus4.cmd_burst, m_burst);
        chk("cmd_size", bus4.cmd_size, m_size);
        chk("cmd_id", bus4.cmd_id, m_id);
        chk("drop_pulse", drop4, m_drop);
    endtask

    initial begin
        rst = 1'b1;
        bus4.req_valid = '0; bus4.req_src_addr = '0; bus4.req_dst_addr = '0;
        bus4.req_burst = '0; bus4.req_len = '0; bus4.req_size = '0; bus4.cmd_ready = 1'b0;
        bus3.req_valid = '0; bus3.req_src_addr = '0; bus3.req_dst_addr = '0;
        bus3.req_burst = '0; bus3.req_len = '0; bus3.req_size = '0; bus3.cmd_ready = 1'b0;
        for (int i = 0; i < N4; i++) begin
            v4[i] = 0; s4[i] = 0; d4[i] = 0; l4[i] = 0; b4[i] = 0; z4[i] = 0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        cyc4(0, 1, w);

        // Full contention with a draining consumer: strict rotation, no bubbles
        for (int i = 0; i < N4; i++) present(i, 32'h1000_0000 + i*256, 32'h2000_0000 + i*256, 64, 2'b01, 3'd3);
        for (int k = 0; k < 8; k++) begin
            cyc4(1, 0, w);
            chk("rr_id", bus4.cmd_id, k % 4);
            chk("rr_src", bus4.cmd_src_addr, 32'h1000_0000 + (k % 4)*256);
            chk("rr_valid", bus4.cmd_valid, 1);
            present(k % 4, 32'h1000_0000 + (k % 4)*256, 32'h2000_0000 + (k % 4)*256, 64, 2'b01, 3'd3);
        end
        clear_all();
        cyc4(1, 0, w);
        chk("drain_empty", bus4.cmd_valid, 0);

        // Back-pressure: one grant, then hold; release accepts the next on the same edge
        present(2, 32'h0000_A000, 32'h0000_B000, 100, 2'b01, 3'd2);
        cyc4(0, 0, w);
        present(2, 32'h0000_A100, 32'h0000_B100, 200, 2'b10, 3'd4);
        repeat (5) begin
            cyc4(0, 0, w);
            chk("hold_src", bus4.cmd_src_addr, 32'h0000_A000);
            chk("hold_valid", bus4.cmd_valid, 1);
        end
        cyc4(1, 0, w);
        chk("next_src", bus4.cmd_src_addr, 32'h0000_A100);
        chk("next_len", bus4.cmd_len, 200);
        cyc4(1, 0, w);

        // Pointer rotation past index 3
        present(3, 32'h3000, 32'h3100, 32, 2'b01, 3'd1);
        cyc4(1, 0, w);
        chk("rot_id3", bus4.cmd_id, 3);
        present(1, 32'h1100, 32'h1200, 24, 2'b01, 3'd1);
        present(3, 32'h3300, 32'h3400, 28, 2'b01, 3'd1);
        cyc4(1, 0, w);
        chk("rot_id1", bus4.cmd_id, 1);
        present(0, 32'h0100, 32'h0200, 20, 2'b01, 3'd1);
        cyc4(1, 0, w);
        chk("rot_id3b", bus4.cmd_id, 3);
        cyc4(1, 0, w);
        chk("rot_id0", bus4.cmd_id, 0);
        cyc4(1, 0, w);

        // Zero-length command is consumed and dropped while the slot drains
        present(3, 32'h3500, 32'h3600, 8, 2'b01, 3'd0);
        cyc4(1, 0, w);
        present(0, 32'h0500, 32'h0600, 0, 2'b01, 3'd0);
        present(1, 32'h1500, 32'h1600, 16, 2'b00, 3'd2);
        cyc4(1, 0, w);
        chk("drop_seen", drop4, 1);
        chk("drop_empty", bus4.cmd_valid, 0);
        cyc4(1, 0, w);
        chk("after_drop_id", bus4.cmd_id, 1);
        chk("after_drop_len", bus4.cmd_len, 16);
        cyc4(1, 0, w);

        // Reset while full with a pending requester
        present(1, 32'h1700, 32'h1800, 40, 2'b01, 3'd2);
        cyc4(0, 0, w);
        present(2, 32'h2700, 32'h2800, 48, 2'b01, 3'd2);
        cyc4(0, 0, w);
        cyc4(0, 1, w);
        chk("rst_valid", bus4.cmd_valid, 0);
        chk("rst_burst", bus4.cmd_burst, 2'b01);
        present(0, 32'h0700, 32'h0800, 56, 2'b01, 3'd2);
        cyc4(1, 0, w);
        chk("rst_prio0", bus4.cmd_id, 0);

        // Random traffic against the reference
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N4; i++) begin
                if (!v4[i] && $urandom_range(0, 2) == 0)
                    present(i, $urandom, $urandom, ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom,
                            2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)));
            end
            cyc4($urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0, w);
        end

        // Three-port instance: wrap at a non-power-of-two count
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < N3; i++) begin
            bus3.req_valid[i]             = 1'b1;
            bus3.req_src_addr[i*AW +: AW] = 32'h0000_C000 + i;
            bus3.req_len[i*LW +: LW]      = 32'(10 + i);
        end
        bus3.cmd_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("n3_id", bus3.cmd_id, k % 3);
            chk("n3_len", bus3.cmd_len, 10 + (k % 3));
            chk("n3_valid", bus3.cmd_valid, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/axi_dma_cmd_arbiter.md
Name: axi_dma_cmd_arbiter

Overview:
- Shares the single command port of axi_dma_controller among NUM_REQ independent requesters using round-robin arbitration.
- Has one registered output slot, so the DMA command port is driven from flops. Downstream throughput is one command per cycle.
- Tags each forwarded command with the winning requester's index, and drops zero-length commands locally.

Parameters:
- NUM_REQ, 4, number of requester ports (2..16).
- ADDR_WD, 32, address width.
- LEN_WD, 32, transfer length field width in bytes.
- ID_WD, $clog2(NUM_REQ), width of the requester index (derived; do not override).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NUM_REQ  per-requester command valid.
- req_src_addr  in  NUM_REQ*ADDR_WD  source addresses; requester i in slice [i*ADDR_WD +: ADDR_WD].
- req_dst_addr  in  NUM_REQ*ADDR_WD  destination addresses, same packing.
- req_burst  in  NUM_REQ*2  AXI burst type per requester.
- req_len  in  NUM_REQ*LEN_WD  byte length per requester.
- req_size  in  NUM_REQ*3  AXI size per requester.
- req_ready  out  NUM_REQ  one-hot accept; combinational.
- cmd_valid  out  1  command valid to the DMA controller.
- cmd_src_addr  out  ADDR_WD  registered source address.
- cmd_dst_addr  out  ADDR_WD  registered destination address.
- cmd_burst  out  2  registered burst type.
- cmd_len  out  LEN_WD  registered length.
- cmd_size  out  3  registered size.
- cmd_id  out  ID_WD  index of the requester that owns the current command.
- cmd_ready  in  1  DMA controller accept.
- drop_pulse  out  1  one-cycle pulse when a zero-length command is consumed.
- busy  out  1  high when any req_valid is set or cmd_valid is high.

Behaviour:
- Handshakes:
  - A transfer occurs on a rising edge with valid&&ready.
  - A requester holds its valid and fields stable until accepted.
  - cmd_valid, once high, stays high with stable fields until cmd_ready.
- Output slot states: EMPTY (cmd_valid=0) and FULL (cmd_valid=1).
  - load_en = EMPTY || (FULL && cmd_ready).
  - Grant is allowed only when load_en=1. This gives back-to-back accepts with no bubble.
- Round-robin arbitration:
  - last_ptr (ID_WD bits) holds the most recent granted index.
  - The search starts at last_ptr+1 modulo NUM_REQ and takes the first set req_valid bit.
  - req_ready[g]=1 only for the winner g, and only when load_en=1. All other bits are 0.
  - last_ptr updates to g on every grant, including dropped grants.
- Grant of a requester with len!=0:
  - The output registers load its fields and cmd_id<=g.
  - The slot becomes or stays FULL.
  - Latency: accept at edge T gives cmd_valid=1 from T+1.
- Grant of a requester with len==0:
  - The command is consumed (req_ready pulses) and not forwarded.
  - drop_pulse=1 in the cycle after acceptance.
  - If the slot was draining that cycle (FULL&&cmd_ready), it goes EMPTY.
- FULL with cmd_ready and no winner: the slot goes EMPTY.
- FULL without cmd_ready: no grant; all req_ready=0. Requesters may still change req_valid.
- Simultaneous drain and load: the new command replaces the old one at the same edge, and cmd_valid stays 1.
- Reset, applied synchronously even mid-transfer, sets:
  - cmd_valid=0 and the slot to EMPTY;
  - cmd_src_addr, cmd_dst_addr, cmd_len, cmd_id = 0;
  - cmd_burst=2'b01 (INCR) and cmd_size=0;
  - drop_pulse=0;
  - last_ptr=NUM_REQ-1, so requester 0 has top priority after reset.
- Reset behaviour of combinational outputs:
  - req_ready is forced to 0 while rst=1.
  - busy reflects its inputs and the slot state.
  - Any pending command is lost; requesters must re-present after reset.
- last_ptr wrap: NUM_REQ-1 wraps to 0. The modulo must be correct for non-power-of-two NUM_REQ.

Test Plan:
- NUM_REQ=4. All four req_valid held high, each with distinct len=64, cmd_ready=1 constantly → grants 0,1,2,3,0,…
  - One command per cycle, no idle cycles.
  - cmd_id sequence matches the grant order.
  - Fields match the owning slice.
- Only requester 2 valid, cmd_ready=0 for 5 cycles → req_ready[2] pulses once.
  - cmd_valid high with stable fields for 5 cycles, with no further grants.
  - After cmd_ready=1 for one cycle, the next command from requester 2 is accepted on that same edge.
- Requesters 1 and 3 valid after last grant was 3 → 1 wins first, then 3.
  - A request of requester 0 arriving later waits until the pointer passes 3.
- Requester 0 len=0, requester 1 len=16, both valid → req_ready[0] pulses.
  - drop_pulse=1 the next cycle and nothing is forwarded for 0.
  - Requester 1 is forwarded with cmd_id=1.
- Reset asserted while FULL with requester 2 pending → next cycle:
  - cmd_valid=0, all req_ready=0, outputs at reset values.
  - After release, with requesters 0 and 2 valid, requester 0 wins.
- NUM_REQ=3, all valid, 9 commands → cmd_id 0,1,2,0,1,2,0,1,2; no index 3 is ever produced.
